// File: rtl/sdcard_pkg.sv
// Shared types and constants for the SPI SD-card responder.
// Holds the FSM state enum, SD command indices, R1 bit positions and CRC7 constants.
// Purely declarative; no logic of its own beyond the R1 byte builder.
package sdcard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
    localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD         = 6'd55;
    localparam logic [5:0] CMD_READ_OCR        = 6'd58;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam int R1_CRC_BIT     = 3;

    localparam logic [6:0] CRC7_POLY = 7'h09;
    localparam int FRAME_BITS = 48;

    // Longest response is R1 plus four payload bytes.
    localparam logic [5:0] RESP_SHORT_BITS = 6'd8;
    localparam logic [5:0] RESP_LONG_BITS  = 6'd40;

    function automatic logic [7:0] r1_byte(input logic idle, input logic illegal, input logic crc);
        logic [7:0] r;
        r = 8'h00;
        r[R1_IDLE_BIT]    = idle;
        r[R1_ILLEGAL_BIT] = illegal;
        r[R1_CRC_BIT]     = crc;
        return r;
    endfunction

endpackage

// File: rtl/spi_sdcard_responder_if.sv
// SPI pin bundle between an SD host (master) and the card responder (slave).
// Combinational wiring only; no latency.
// No flow control: the host owns SCLK and chip select.
interface spi_sdcard_responder_if;
    logic spisdcard_clk;
    logic spisdcard_cs_n;
    logic spisdcard_mosi;
    logic spisdcard_miso;

    modport master (
        output spisdcard_clk,
        output spisdcard_cs_n,
        output spisdcard_mosi,
        input  spisdcard_miso
    );

    modport slave (
        input  spisdcard_clk,
        input  spisdcard_cs_n,
        input  spisdcard_mosi,
        output spisdcard_miso
    );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1) over command frame bits, MSB first.
// Remainder updates one cycle after each enabled bit.
// No backpressure; caller gates with enable.
module sd_crc7
    import sdcard_pkg::*;
(
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic feedback;
    assign feedback = bit_in ^ crc[6];

    // Shift the remainder, folding in the polynomial when the feedback bit is set.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            crc <= 7'h00;
        end else if (clear) begin
            crc <= 7'h00;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/spi_sdcard_responder.sv
// SD-card SPI-mode command responder: decodes 48-bit frames, answers R1/R3/R7.
// Response starts after one Ncr byte of 1s; MISO changes on synchronized SCLK falls.
// No backpressure; chip select high aborts to IDLE at once.
module spi_sdcard_responder
    import sdcard_pkg::*;
#(
    parameter int          ACMD41_BUSY_COUNT = 2,
    parameter logic [31:0] OCR_VALUE         = 32'hC0FF8000
)
(
    input  logic                   clk50,
    input  logic                   reset_n,
    spi_sdcard_responder_if.slave  spi,
    output logic                   cmd_valid,
    output logic [5:0]             cmd_index,
    output logic [31:0]            cmd_arg,
    output logic                   crc_err,
    output logic                   in_idle
);

    localparam logic [7:0] BUSY_LIMIT = 8'(ACMD41_BUSY_COUNT);

    // ---------------- synchronizers and edge detect ----------------
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_high;
    logic       mosi_bit;

    // Two-flop synchronizers on every host pin plus one SCLK history flop.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi.spisdcard_clk};
            cs_sync   <= {cs_sync[0], spi.spisdcard_cs_n};
            mosi_sync <= {mosi_sync[0], spi.spisdcard_mosi};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign cs_high   = cs_sync[1];
    assign mosi_bit  = mosi_sync[1];

    // ---------------- state and datapath registers ----------------
    state_t      state;
    state_t      state_next;
    logic [45:0] shreg;       // frame bit k (1..46) lands in shreg[k-1]
    logic [5:0]  bit_cnt;     // index of the frame bit expected on the next rise
    logic [2:0]  gap_cnt;
    logic [39:0] resp_sr;
    logic [5:0]  resp_left;
    logic        miso_q;
    logic        app_flag;
    logic [7:0]  acmd_cnt;

    logic        crc_clear;
    logic        crc_en;
    logic        frame_done;
    logic [6:0]  crc_rem;

    sd_crc7 u_crc7 (
        .clk50   (clk50),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .enable  (crc_en),
        .bit_in  (mosi_bit),
        .crc     (crc_rem)
    );

    // Next-state and per-cycle strobes; chip select high overrides everything.
    always_comb begin
        state_next = state;
        crc_clear  = 1'b0;
        crc_en     = 1'b0;
        frame_done = 1'b0;
        if (cs_high) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // The start bit (bit 47) is 0 and leaves a cleared CRC at 0,
                    // so clearing here is equivalent to feeding it.
                    if (sclk_rise && !mosi_bit) begin
                        state_next = CMD;
                        crc_clear  = 1'b1;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        crc_en = (bit_cnt >= 6'd8);
                        if (bit_cnt == 6'd0) begin
                            frame_done = 1'b1;
                            state_next = GAP;
                        end
                    end
                end
                GAP: begin
                    if (sclk_fall && gap_cnt == 3'd7) begin
                        state_next = RESP;
                    end
                end
                RESP: begin
                    if (sclk_fall && resp_left == 6'd0) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- frame decode ----------------
    logic        f_tx;
    logic [5:0]  f_idx;
    logic [31:0] f_arg;
    logic [6:0]  f_crc;
    logic        frame_bad;

    assign f_tx      = shreg[45];
    assign f_idx     = shreg[44:39];
    assign f_arg     = shreg[38:7];
    assign f_crc     = shreg[6:0];
    assign frame_bad = (crc_rem != f_crc) | ~f_tx | ~mosi_bit;

    // ---------------- command evaluation ----------------
    logic        idle_nxt;
    logic        app_nxt;
    logic [7:0]  acmd_nxt;
    logic        illegal;
    logic        crc_flag;
    logic        long_resp;
    logic [31:0] tail;
    logic [39:0] resp_word;

    // Card-state update and response word for the frame completing this cycle.
    always_comb begin
        idle_nxt  = in_idle;
        acmd_nxt  = acmd_cnt;
        app_nxt   = 1'b0;
        illegal   = 1'b0;
        crc_flag  = 1'b0;
        long_resp = 1'b0;
        tail      = 32'h0;
        if ((f_idx == CMD_GO_IDLE || f_idx == CMD_SEND_IF_COND) && frame_bad) begin
            crc_flag = 1'b1;
        end else if (f_idx == CMD_GO_IDLE) begin
            idle_nxt = 1'b1;
            acmd_nxt = 8'h00;
        end else if (f_idx == CMD_SEND_IF_COND) begin
            long_resp = 1'b1;
            tail      = f_arg;
        end else if (f_idx == CMD_APP_CMD) begin
            app_nxt = 1'b1;
        end else if (f_idx == CMD_SD_SEND_OP_COND && app_flag) begin
            // Counter saturates at the limit; the call that finds it there leaves idle.
            if (acmd_cnt >= BUSY_LIMIT) begin
                idle_nxt = 1'b0;
            end else begin
                acmd_nxt = acmd_cnt + 8'd1;
            end
        end else if (f_idx == CMD_READ_OCR) begin
            long_resp = 1'b1;
            tail      = OCR_VALUE;
        end else begin
            illegal = 1'b1;
        end
        resp_word = {r1_byte(idle_nxt, illegal, crc_flag), tail};
    end

    // Frame shifting, Ncr gap counting and response shifting.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            shreg     <= '0;
            bit_cnt   <= 6'd0;
            gap_cnt   <= 3'd0;
            resp_sr   <= '0;
            resp_left <= 6'd0;
        end else if (crc_clear) begin
            bit_cnt <= 6'(FRAME_BITS - 2);
        end else if (frame_done) begin
            gap_cnt   <= 3'd0;
            resp_sr   <= resp_word;
            resp_left <= long_resp ? RESP_LONG_BITS : RESP_SHORT_BITS;
        end else if (!cs_high) begin
            if (state == CMD && sclk_rise) begin
                shreg <= {shreg[44:0], mosi_bit};
                if (bit_cnt != 6'd0) begin
                    bit_cnt <= bit_cnt - 6'd1;
                end
            end else if (state == GAP && sclk_fall) begin
                gap_cnt <= gap_cnt + 3'd1;
            end else if (state == RESP && sclk_fall && resp_left != 6'd0) begin
                resp_sr   <= {resp_sr[38:0], 1'b0};
                resp_left <= resp_left - 6'd1;
            end
        end
    end

    // Latched frame fields and persistent card state.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd_index <= 6'd0;
            cmd_arg   <= 32'h0;
            crc_err   <= 1'b0;
            in_idle   <= 1'b1;
            app_flag  <= 1'b0;
            acmd_cnt  <= 8'h00;
        end else begin
            cmd_valid <= frame_done;
            if (frame_done) begin
                cmd_index <= f_idx;
                cmd_arg   <= f_arg;
                crc_err   <= frame_bad;
                in_idle   <= idle_nxt;
                app_flag  <= app_nxt;
                acmd_cnt  <= acmd_nxt;
            end
        end
    end

    // MISO idles high everywhere except while response bits are being shifted.
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            miso_q <= 1'b1;
        end else if (cs_high || state != RESP) begin
            miso_q <= 1'b1;
        end else if (sclk_fall) begin
            miso_q <= (resp_left != 6'd0) ? resp_sr[39] : 1'b1;
        end
    end

    assign spi.spisdcard_miso = miso_q;

endmodule

// File: tb/tb_spi_sdcard_responder.sv
// Directed bench for spi_sdcard_responder: table of frames with expected replies,
// plus hand sequences for chip-select abort and reset during a response.
module tb_spi_sdcard_responder;
    import sdcard_pkg::*;

    localparam int H = 8;   // SCLK half period in clk50 cycles

    logic        clk50;
    logic        reset_n;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        crc_err;
    logic        in_idle;

    spi_sdcard_responder_if spi_if ();

    spi_sdcard_responder #(
        .ACMD41_BUSY_COUNT (2),
        .OCR_VALUE         (32'hC0FF8000)
    ) dut (
        .clk50     (clk50),
        .reset_n   (reset_n),
        .spi       (spi_if.slave),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .crc_err   (crc_err),
        .in_idle   (in_idle)
    );

    initial clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    int vld_cnt = 0;
    always @(posedge clk50) if (cmd_valid) vld_cnt = vld_cnt + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [47:0] frame;
        int          nbytes;
        logic [39:0] resp;      // left-aligned reply bytes
        logic [5:0]  idx;
        logic [31:0] arg;
        logic        crc_err;
        logic        idle;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic xfer_bit(input logic mo, output logic mi);
        spi_if.spisdcard_mosi = mo;
        repeat (H) @(negedge clk50);
        mi = spi_if.spisdcard_miso;
        spi_if.spisdcard_clk = 1'b1;
        repeat (H) @(negedge clk50);
        spi_if.spisdcard_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [47:0] f, input int n);
        logic dummy;
        for (int i = 47; i > 47 - n; i--) xfer_bit(f[i], dummy);
    endtask

    task automatic read_bits(input int n, output logic [39:0] got);
        logic b;
        got = '0;
        for (int i = 0; i < n; i++) begin
            xfer_bit(1'b1, b);
            got = {got[38:0], b};
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int          v0;
        logic [39:0] gap;
        logic [39:0] got;
        v0 = vld_cnt;
        send_bits(v.frame, 48);
        read_bits(8, gap);
        chk({tag, " gap"}, {56'h0, gap[7:0]}, 64'hFF);
        read_bits(8 * v.nbytes, got);
        chk({tag, " resp"}, {24'h0, got}, {24'h0, v.resp >> (40 - 8 * v.nbytes)});
        chk({tag, " cmd_valid count"}, 64'(vld_cnt - v0), 64'd1);
        chk({tag, " cmd_index"}, {58'h0, cmd_index}, {58'h0, v.idx});
        chk({tag, " cmd_arg"}, {32'h0, cmd_arg}, {32'h0, v.arg});
        chk({tag, " crc_err"}, {63'h0, crc_err}, {63'h0, v.crc_err});
        chk({tag, " in_idle"}, {63'h0, in_idle}, {63'h0, v.idle});
        repeat (H) @(negedge clk50);
        chk({tag, " miso idle"}, {63'h0, spi_if.spisdcard_miso}, 64'h1);
    endtask

    initial begin
        vec_t        cmd0;
        vec_t        cmd8;
        logic [39:0] tmp;
        int          v0;

        cmd0 = '{48'h40_00000000_95, 1, {8'h01, 32'h0}, 6'd0, 32'h0, 1'b0, 1'b1};
        cmd8 = '{48'h48_000001AA_87, 5, 40'h00_000001AA, 6'd8, 32'h1AA, 1'b0, 1'b0};

        vecs[0]  = cmd0;
        vecs[1]  = '{48'h48_000001AA_87, 5, 40'h01_000001AA, 6'd8,  32'h1AA,      1'b0, 1'b1};
        vecs[2]  = '{48'h40_00000000_00, 1, {8'h09, 32'h0},  6'd0,  32'h0,        1'b1, 1'b1};
        vecs[3]  = '{48'h77_00000000_65, 1, {8'h01, 32'h0},  6'd55, 32'h0,        1'b0, 1'b1};
        vecs[4]  = '{48'h69_40000000_77, 1, {8'h01, 32'h0},  6'd41, 32'h40000000, 1'b0, 1'b1};
        vecs[5]  = vecs[3];
        vecs[6]  = vecs[4];
        vecs[7]  = vecs[3];
        vecs[8]  = '{48'h69_40000000_77, 1, {8'h00, 32'h0},  6'd41, 32'h40000000, 1'b0, 1'b0};
        vecs[9]  = '{48'h7A_00000000_FD, 5, 40'h00_C0FF8000, 6'd58, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{48'h00_00000000_95, 1, {8'h08, 32'h0},  6'd0,  32'h0,        1'b1, 1'b0};
        vecs[11] = '{48'h48_000001AA_86, 1, {8'h08, 32'h0},  6'd8,  32'h1AA,      1'b1, 1'b0};
        vecs[12] = '{48'h77_00000000_65, 1, {8'h00, 32'h0},  6'd55, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{48'h41_00000000_F9, 1, {8'h04, 32'h0},  6'd1,  32'h0,        1'b0, 1'b0};
        vecs[14] = '{48'h69_40000000_77, 1, {8'h04, 32'h0},  6'd41, 32'h40000000, 1'b0, 1'b0};

        reset_n = 1'b0;
        spi_if.spisdcard_clk  = 1'b0;
        spi_if.spisdcard_cs_n = 1'b1;
        spi_if.spisdcard_mosi = 1'b1;
        repeat (5) @(negedge clk50);
        chk("reset miso", {63'h0, spi_if.spisdcard_miso}, 64'h1);
        chk("reset cmd_valid", {63'h0, cmd_valid}, 64'h0);
        chk("reset cmd_index", {58'h0, cmd_index}, 64'h0);
        chk("reset cmd_arg", {32'h0, cmd_arg}, 64'h0);
        chk("reset crc_err", {63'h0, crc_err}, 64'h0);
        chk("reset in_idle", {63'h0, in_idle}, 64'h1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk50);
        spi_if.spisdcard_cs_n = 1'b0;
        repeat (5) @(negedge clk50);

        for (int i = 0; i < 15; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset while the CMD8 echo is on byte 2 (a 0x00 byte).
        send_bits(cmd8.frame, 48);
        read_bits(8, tmp);
        read_bits(16, tmp);
        chk("pre-reset bytes0-1", {24'h0, tmp}, 64'h0000);
        read_bits(3, tmp);
        repeat (H) @(negedge clk50);
        chk("pre-reset miso", {63'h0, spi_if.spisdcard_miso}, 64'h0);
        reset_n = 1'b0;
        #1;
        chk("reset-mid miso", {63'h0, spi_if.spisdcard_miso}, 64'h1);
        chk("reset-mid in_idle", {63'h0, in_idle}, 64'h1);
        repeat (3) @(negedge clk50);
        reset_n = 1'b1;
        repeat (5) @(negedge clk50);
        run_vec("after-reset cmd0", cmd0);

        // Chip select raised 20 bits into a frame.
        v0 = vld_cnt;
        send_bits(cmd0.frame, 20);
        spi_if.spisdcard_cs_n = 1'b1;
        repeat (10) @(negedge clk50);
        chk("abort miso", {63'h0, spi_if.spisdcard_miso}, 64'h1);
        chk("abort cmd_valid count", 64'(vld_cnt - v0), 64'd0);
        spi_if.spisdcard_cs_n = 1'b0;
        repeat (5) @(negedge clk50);
        run_vec("after-abort cmd0", cmd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_sdcard_responder.md
SPI_SDCARD_RESPONDER -- requirements
Module: spi_sdcard_responder

Interface
REQ-001 SHALL have parameter ACMD41_BUSY_COUNT, default 2, number of ACMD41 replies with idle bit still set.
REQ-002 SHALL have parameter OCR_VALUE, default 32'hC0FF8000, returned by CMD58.
REQ-003 SHALL have port clk50, input, 1 bit, sole clock, 50 MHz.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port spisdcard_clk, input, 1 bit, SPI clock from host, mode 0, at most clk50/4.
REQ-006 SHALL have port spisdcard_cs_n, input, 1 bit, active-low chip select.
REQ-007 SHALL have port spisdcard_mosi, input, 1 bit, host-to-card data, MSB first.
REQ-008 SHALL have port spisdcard_miso, output, 1 bit, card-to-host data, MSB first.
REQ-009 SHALL have port cmd_valid, output, 1 bit, one-cycle pulse when a complete frame is latched.
REQ-010 SHALL have port cmd_index, output, 6 bits, index of the last latched frame.
REQ-011 SHALL have port cmd_arg, output, 32 bits, argument of the last latched frame.
REQ-012 SHALL have port crc_err, output, 1 bit, high when the last frame failed CRC7; held until the next frame.
REQ-013 SHALL have port in_idle, output, 1 bit, card idle-state flag.

Function
REQ-014 SHALL pass spisdcard_clk, spisdcard_cs_n and spisdcard_mosi through 2-flop synchronizers and detect SCLK edges in the clk50 domain.
REQ-015 SHALL sample MOSI on the synchronized SCLK rising edge and update MISO on the falling edge.
REQ-016 SHALL implement FSM states IDLE, CMD, GAP and RESP.
REQ-017 IDLE: MISO=1; the first sampled 0 with cs_n low SHALL enter CMD, counting that 0 as frame bit 47.
REQ-018 CMD: SHALL shift the remaining 47 bits; after bit 0, SHALL latch index/arg, pulse cmd_valid, compute crc_err, and enter GAP.
REQ-019 The transmission bit (bit 46) SHALL be 1 and the end bit SHALL be 1; otherwise the frame SHALL be treated as a CRC error.
REQ-020 GAP: SHALL drive 8 bits of 1 (Ncr = 1 byte), then enter RESP.
REQ-021 RESP: SHALL shift out the response bytes, then return to IDLE with MISO=1.
REQ-022 Response table (R1 bit0 = in_idle):
  - CMD0: sets in_idle=1, resets the ACMD41 counter, R1.
  - CMD8: R1 followed by the 4 argument bytes echoed.
  - CMD55: R1, arms the app flag.
  - ACMD41: R1; in_idle clears on the (ACMD41_BUSY_COUNT+1)th call.
  - CMD58: R1 followed by OCR_VALUE.
  - Any other index, or index 41 without the app flag: R1 with bit2 set (illegal command).
REQ-023 The app flag SHALL clear after any command that follows CMD55.
REQ-024 crc_err SHALL be checked on CMD0 and CMD8 only; on failure the response SHALL be R1 with bit3 set, and card state SHALL be unchanged.
REQ-025 MOSI bits received in GAP/RESP SHALL be ignored; there is no command pipelining.
REQ-026 cs_n rising in any state SHALL abort to IDLE at once, drive MISO=1, and discard any partial frame; in_idle, the app flag and the counter SHALL be retained.
REQ-027 The response shift counter SHALL cover at most 5 bytes; a counter wrap SHALL never occur.

Reset
REQ-028 On reset_n low, asynchronously: FSM=IDLE, spisdcard_miso=1, cmd_valid=0, cmd_index=0, cmd_arg=0, crc_err=0, in_idle=1, app flag=0, ACMD41 counter=0, synchronizer flops=1 (clk: 0).
REQ-029 Reset mid-response SHALL truncate the response; the next frame after release SHALL be decoded normally.

Structure
REQ-030 Package sdcard_pkg SHALL hold: the FSM state enum, command index constants (0, 8, 41, 55, 58), R1 bit positions, the CRC7 polynomial 7'h09, and the frame length 48.
REQ-031 Serial CRC7 SHALL be a sub-module sd_crc7 (clear, enable, bit in, 7-bit remainder), cleared on entry to CMD.

Verification
REQ-032 CMD0 frame 40 00 00 00 00 95 -> 8 bits of 1, then R1=0x01; cmd_valid pulse with index 0.
REQ-033 CMD8 frame 48 00 00 01 AA 87 -> 0x01 00 00 01 AA.
REQ-034 CMD0 with CRC byte 0x00 -> R1=0x09, crc_err=1, in_idle unchanged.
REQ-035 With ACMD41_BUSY_COUNT=2, send (CMD55 77 00 00 00 00 65, ACMD41 69 40 00 00 00 77) three times -> ACMD41 replies 0x01, 0x01, 0x00; then CMD58 -> 0x00 C0 FF 80 00.
REQ-036 Raise cs_n after 20 frame bits -> no cmd_valid, MISO=1; the next CMD0 is answered 0x01.
REQ-037 Pulse reset_n low during RESP byte 2 of CMD8 -> MISO=1 immediately and in_idle=1; a following CMD0 is answered 0x01.
